// File: rtl/rj45_serial_pkg.sv
// Shared types and constants for the RJ45 serial frame receiver.
package rj45_serial_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } rx_state_t;

   localparam logic [15:0]  DEFAULT_SYNC_WORD      = 16'hA5C3;
   localparam int unsigned  DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int unsigned  CHECK_BITS             = 8;

   // XOR of the four bytes of a word; narrower words arrive zero-extended
   function automatic logic [7:0] byte_xor(input logic [31:0] word);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 4; i++) begin
         acc = acc ^ word[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/rj45_serial_sync_edge.sv
// Two-flop synchronizers for the remote bit clock and data, plus a registered
// rising-edge strobe with the data bit captured alongside it.
module rj45_serial_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_serial_clk,
   input  logic i_serial_data,
   output logic o_edge,
   output logic o_data
);

   logic [1:0] r_clk_sync;
   logic [1:0] r_data_sync;
   logic       r_clk_prev;
   logic       r_edge;
   logic       r_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync  <= 2'b00;
         r_data_sync <= 2'b00;
         r_clk_prev  <= 1'b0;
         r_edge      <= 1'b0;
         r_data      <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_serial_clk};
         r_data_sync <= {r_data_sync[0], i_serial_data};
         r_clk_prev  <= r_clk_sync[1];
         r_edge      <= r_clk_sync[1] & ~r_clk_prev;
         r_data      <= r_data_sync[1];
      end
   end

   assign o_edge = r_edge;
   assign o_data = r_data;

endmodule

// File: rtl/rj45_serial_rx.sv
// Serial frame receiver: hunts for a sync word, deserialises NUM_CHANNELS
// words, then verifies a trailing byte-XOR checksum.
module rj45_serial_rx
   import rj45_serial_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_CHANNELS   = 2,
   parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_clk_in,
   input  logic                  serial_data_in,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic [3:0]            rx_channel,
   output logic                  rx_valid,
   output logic                  rx_startofpacket,
   output logic                  rx_endofpacket,
   output logic                  frame_error,
   output logic                  locked
);

   localparam int unsigned BIT_CNT_W = 6;
   localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);

   rx_state_t             r_state;
   logic [15:0]           r_sync_shift;
   logic [DATA_WIDTH-1:0] r_word_shift;
   logic [BIT_CNT_W-1:0]  r_bit_cnt;
   logic [3:0]            r_channel;
   logic [7:0]            r_csum;
   logic [IDLE_W-1:0]     r_idle;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic [3:0]            r_rx_channel;
   logic                  r_rx_valid;
   logic                  r_sop;
   logic                  r_eop;
   logic                  r_frame_error;
   logic                  r_locked;

   logic                  w_edge;
   logic                  w_bit;
   logic [15:0]           w_sync_next;
   logic [DATA_WIDTH-1:0] w_word_next;
   logic [7:0]            w_word_csum;
   logic                  w_last_bit;
   logic                  w_last_chan;
   logic                  w_check_done;
   logic                  w_timeout;

   rj45_serial_sync_edge u_sync_edge (
      .clk          (clk),
      .reset        (reset),
      .i_serial_clk (serial_clk_in),
      .i_serial_data(serial_data_in),
      .o_edge       (w_edge),
      .o_data       (w_bit)
   );

   assign w_sync_next  = {r_sync_shift[14:0], w_bit};
   assign w_word_next  = {r_word_shift[DATA_WIDTH-2:0], w_bit};
   assign w_word_csum  = byte_xor(32'(w_word_next));
   assign w_last_bit   = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
   assign w_last_chan  = (r_channel == 4'(NUM_CHANNELS - 1));
   assign w_check_done = (r_bit_cnt == BIT_CNT_W'(CHECK_BITS - 1));
   assign w_timeout    = (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

   // Frame FSM; an edge always takes priority over the idle timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= HUNT;
         r_sync_shift  <= '0;
         r_word_shift  <= '0;
         r_bit_cnt     <= '0;
         r_channel     <= '0;
         r_csum        <= '0;
         r_idle        <= '0;
         r_rx_data     <= '0;
         r_rx_channel  <= '0;
         r_rx_valid    <= 1'b0;
         r_sop         <= 1'b0;
         r_eop         <= 1'b0;
         r_frame_error <= 1'b0;
         r_locked      <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_sop         <= 1'b0;
         r_eop         <= 1'b0;
         r_frame_error <= 1'b0;
         case (r_state)
            HUNT: begin
               r_idle <= '0;
               if (w_edge) begin
                  r_sync_shift <= w_sync_next;
                  if (w_sync_next == SYNC_WORD) begin
                     r_state   <= DATA;
                     r_bit_cnt <= '0;
                     r_channel <= '0;
                     r_csum    <= '0;
                  end
               end
            end
            DATA: begin
               if (w_edge) begin
                  r_idle       <= '0;
                  r_word_shift <= w_word_next;
                  if (w_last_bit) begin
                     r_bit_cnt    <= '0;
                     r_rx_data    <= w_word_next;
                     r_rx_channel <= r_channel;
                     r_rx_valid   <= 1'b1;
                     r_sop        <= (r_channel == 4'd0);
                     r_eop        <= w_last_chan;
                     r_csum       <= r_csum ^ w_word_csum;
                     if (w_last_chan) begin
                        r_state <= CHECK;
                     end else begin
                        r_channel <= r_channel + 4'd1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                  end
               end else if (w_timeout) begin
                  r_frame_error <= 1'b1;
                  r_locked      <= 1'b0;
                  r_state       <= HUNT;
                  r_sync_shift  <= '0;
               end else begin
                  r_idle <= r_idle + IDLE_W'(1);
               end
            end
            CHECK: begin
               if (w_edge) begin
                  r_idle       <= '0;
                  r_word_shift <= w_word_next;
                  if (w_check_done) begin
                     if (w_word_next[7:0] == r_csum) begin
                        r_locked <= 1'b1;
                     end else begin
                        r_frame_error <= 1'b1;
                        r_locked      <= 1'b0;
                     end
                     r_state      <= HUNT;
                     r_sync_shift <= '0;
                     r_bit_cnt    <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                  end
               end else if (w_timeout) begin
                  r_frame_error <= 1'b1;
                  r_locked      <= 1'b0;
                  r_state       <= HUNT;
                  r_sync_shift  <= '0;
               end else begin
                  r_idle <= r_idle + IDLE_W'(1);
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

   assign rx_data          = r_rx_data;
   assign rx_channel       = r_rx_channel;
   assign rx_valid         = r_rx_valid;
   assign rx_startofpacket = r_sop;
   assign rx_endofpacket   = r_eop;
   assign frame_error      = r_frame_error;
   assign locked           = r_locked;

endmodule

// File: tb/tb_rj45_serial_rx.sv
// Directed bench for rj45_serial_rx: good frames, checksum errors, timeouts,
// sliding sync alignment and mid-frame reset.
module tb_rj45_serial_rx;
   import rj45_serial_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NC = 2;
   localparam int unsigned TO = 64;
   localparam logic [15:0] SYNC = 16'hA5C3;

   logic          clk = 1'b0;
   logic          reset;
   logic          sclk;
   logic          sdata;
   logic [DW-1:0] rx_data;
   logic [3:0]    rx_channel;
   logic          rx_valid;
   logic          rx_sop;
   logic          rx_eop;
   logic          frame_error;
   logic          locked;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  ch;
      logic        sop;
      logic        eop;
   } beat_t;

   beat_t q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   int    err_cnt  = 0;
   int    err_cyc  = 0;

   always #5 clk = ~clk;

   rj45_serial_rx #(
      .DATA_WIDTH    (DW),
      .NUM_CHANNELS  (NC),
      .SYNC_WORD     (SYNC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .serial_clk_in   (sclk),
      .serial_data_in  (sdata),
      .rx_data         (rx_data),
      .rx_channel      (rx_channel),
      .rx_valid        (rx_valid),
      .rx_startofpacket(rx_sop),
      .rx_endofpacket  (rx_eop),
      .frame_error     (frame_error),
      .locked          (locked)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) q.push_back('{rx_data, rx_channel, rx_sop, rx_eop});
      if (frame_error) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Low phase of 2 cycles with data set, then rising edge held for hi cycles
   task automatic send_bit(input logic b, input int hi);
      sclk = 1'b0;
      sdata = b;
      step(2);
      sclk = 1'b1;
      step(hi);
   endtask

   task automatic send_word(input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], 2);
   endtask

   task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] cs);
      send_word(32'(SYNC), 16);
      send_word(w0, 32);
      send_word(w1, 32);
      send_word(32'(cs), 8);
      step(8);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sclk = 1'b0;
      sdata = 1'b0;
      step(3);
      checks++;
      if (rx_data !== 32'h0) begin
         failures++; $display("FAIL reset_data: got %h expected 0", rx_data);
      end
      checks++;
      if ({rx_channel, rx_valid, rx_sop, rx_eop, frame_error, locked} !== 9'h0) begin
         failures++; $display("FAIL reset_flags: got %b expected 0", {rx_channel, rx_valid, rx_sop, rx_eop, frame_error, locked});
      end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_good_frame();
      q.delete();
      err_cnt = 0;
      send_frame(32'h12345678, 32'h9ABCDEF0, 8'h00);
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL good_count: got %0d expected 2", q.size());
      end else begin
         checks++;
         if ({q[0].data, q[0].ch, q[0].sop, q[0].eop} !== {32'h12345678, 4'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL good_beat0: got %h/%0d/%b%b expected 12345678/0/10", q[0].data, q[0].ch, q[0].sop, q[0].eop);
         end
         checks++;
         if ({q[1].data, q[1].ch, q[1].sop, q[1].eop} !== {32'h9ABCDEF0, 4'd1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL good_beat1: got %h/%0d/%b%b expected 9abcdef0/1/01", q[1].data, q[1].ch, q[1].sop, q[1].eop);
         end
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++; $display("FAIL good_locked: got %b expected 1", locked);
      end
      checks++;
      if (err_cnt != 0) begin
         failures++; $display("FAIL good_errors: got %0d expected 0", err_cnt);
      end
   endtask

   task automatic test_checksum();
      q.delete();
      err_cnt = 0;
      send_frame(32'h12345678, 32'hDEADBEEF, 8'h2A);
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL csum_ok_count: got %0d expected 2", q.size());
      end else begin
         checks++;
         if ({q[1].data, q[1].ch, q[1].eop} !== {32'hDEADBEEF, 4'd1, 1'b1}) begin
            failures++; $display("FAIL csum_ok_beat1: got %h/%0d/%b expected deadbeef/1/1", q[1].data, q[1].ch, q[1].eop);
         end
      end
      checks++;
      if (locked !== 1'b1 || err_cnt != 0) begin
         failures++; $display("FAIL csum_ok_status: got locked=%b errs=%0d expected locked=1 errs=0", locked, err_cnt);
      end
      q.delete();
      err_cnt = 0;
      send_frame(32'h12345678, 32'hDEADBEEF, 8'h2B);
      checks++;
      if (err_cnt != 1) begin
         failures++; $display("FAIL csum_bad_errors: got %0d expected 1", err_cnt);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++; $display("FAIL csum_bad_locked: got %b expected 0", locked);
      end
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL csum_bad_words_kept: got %0d expected 2", q.size());
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      int          rise_cyc;
      w = 32'h12345678;
      q.delete();
      err_cnt = 0;
      send_word(32'(SYNC), 16);
      for (int i = 31; i > 22; i--) send_bit(w[i], 2);
      sclk = 1'b0;
      sdata = w[22];
      step(2);
      sclk = 1'b1;
      rise_cyc = cyc;
      for (int k = 0; k < int'(TO) + 40 && err_cnt == 0; k++) step(1);
      step(4);
      checks++;
      if (err_cnt != 1) begin
         failures++; $display("FAIL timeout_errors: got %0d expected 1", err_cnt);
      end
      // three sync stages plus the FSM register sit between the pin edge and the idle restart
      checks++;
      if (err_cyc - rise_cyc != int'(TO) + 4) begin
         failures++; $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - rise_cyc, TO + 4);
      end
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL timeout_no_valid: got %0d expected 0", q.size());
      end
      checks++;
      if (dut.r_state !== HUNT) begin
         failures++; $display("FAIL timeout_state: got %0d expected %0d", dut.r_state, HUNT);
      end
   endtask

   task automatic test_noise();
      q.delete();
      err_cnt = 0;
      send_word(32'h0000FFA5, 16);
      step(8);
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL noise_quiet: got %0d expected 0", q.size());
      end
      send_frame(32'h12345678, 32'h9ABCDEF0, 8'h00);
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL noise_count: got %0d expected 2", q.size());
      end else begin
         checks++;
         if ({q[0].data, q[1].data} !== {32'h12345678, 32'h9ABCDEF0}) begin
            failures++; $display("FAIL noise_data: got %h %h expected 12345678 9abcdef0", q[0].data, q[1].data);
         end
      end
      checks++;
      if (locked !== 1'b1 || err_cnt != 0) begin
         failures++; $display("FAIL noise_status: got locked=%b errs=%0d expected locked=1 errs=0", locked, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      w = 32'h9ABCDEF0;
      err_cnt = 0;
      send_word(32'(SYNC), 16);
      send_word(32'h12345678, 32);
      for (int i = 31; i > 21; i--) send_bit(w[i], 2);
      reset = 1'b1;
      sclk = 1'b0;
      #1;
      checks++;
      if (rx_data !== 32'h0) begin
         failures++; $display("FAIL midreset_data: got %h expected 0", rx_data);
      end
      checks++;
      if ({rx_channel, rx_valid, rx_sop, rx_eop, frame_error, locked} !== 9'h0) begin
         failures++; $display("FAIL midreset_flags: got %b expected 0", {rx_channel, rx_valid, rx_sop, rx_eop, frame_error, locked});
      end
      step(2);
      reset = 1'b0;
      step(2);
      q.delete();
      send_frame(32'h12345678, 32'hDEADBEEF, 8'h2A);
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL midreset_count: got %0d expected 2", q.size());
      end else begin
         checks++;
         if ({q[0].data, q[1].data} !== {32'h12345678, 32'hDEADBEEF}) begin
            failures++; $display("FAIL midreset_data2: got %h %h expected 12345678 deadbeef", q[0].data, q[1].data);
         end
      end
      checks++;
      if (locked !== 1'b1 || err_cnt != 0) begin
         failures++; $display("FAIL midreset_status: got locked=%b errs=%0d expected locked=1 errs=0", locked, err_cnt);
      end
   endtask

   task automatic test_edge_at_timeout();
      logic [31:0] w;
      w = 32'h12345678;
      q.delete();
      err_cnt = 0;
      send_word(32'(SYNC), 16);
      for (int i = 31; i >= 0; i--) send_bit(w[i], (i == 26) ? int'(TO) - 2 : 2);
      send_word(32'h9ABCDEF0, 32);
      send_word(32'h00000000, 8);
      step(8);
      checks++;
      if (err_cnt != 0) begin
         failures++; $display("FAIL edge_win_errors: got %0d expected 0", err_cnt);
      end
      checks++;
      if (q.size() != 2) begin
         failures++; $display("FAIL edge_win_count: got %0d expected 2", q.size());
      end else begin
         checks++;
         if (q[0].data !== 32'h12345678) begin
            failures++; $display("FAIL edge_win_data: got %h expected 12345678", q[0].data);
         end
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++; $display("FAIL edge_win_locked: got %b expected 1", locked);
      end
      // one cycle longer than the timeout must abort
      q.delete();
      err_cnt = 0;
      send_word(32'(SYNC), 16);
      for (int i = 31; i > 26; i--) send_bit(w[i], 2);
      send_bit(w[26], int'(TO) - 1);
      send_bit(w[25], 2);
      step(8);
      checks++;
      if (err_cnt != 1) begin
         failures++; $display("FAIL edge_late_errors: got %0d expected 1", err_cnt);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++; $display("FAIL edge_late_locked: got %b expected 0", locked);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_checksum();
      test_timeout();
      test_noise();
      test_reset_mid();
      test_edge_at_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
